// File: rtl/mode_counter_pkg.sv
// Shared encodings for mode_counter: end-of-range modes and one-shot FSM states.
package mode_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

endpackage : mode_counter_pkg

// File: rtl/mode_counter_prescaler.sv
// Enable qualifier for mode_counter: emits one step per presc_div+1 enabled cycles.
module mode_counter_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  enab,
    input  logic [PRESCALE_W-1:0] presc_div,
    output logic                  step
);

    logic [PRESCALE_W-1:0] div_cnt_q;
    logic [PRESCALE_W-1:0] div_cnt_d;
    logic                  tick;

    // >= keeps the divider from running away if presc_div is lowered mid-count.
    assign tick = enab && (div_cnt_q >= presc_div);
    assign step = tick;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (enab) begin
            if (tick) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule : mode_counter_prescaler

// File: rtl/mode_counter.sv
// Up/down counter with runtime bound and WRAP/SAT/ONESHOT end-of-range modes.
// Optional enable prescaler (presc_div port) is built when MODE_COUNTER_PRESCALE_EN is defined.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  enab,
    input  logic                  up_dn,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic [WIDTH-1:0]      max_val,
`ifdef MODE_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc_div,
`endif
    output logic [WIDTH-1:0]      cnt_out,
    output logic                  tc,
    output logic                  done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    state_t           state_q, state_d;

    logic             step;
    logic             is_oneshot;
    logic [WIDTH-1:0] bound;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;
    logic [WIDTH-1:0] cnt_os;

    // Zero-width parameters make no sense for either counter or prescaler.
    if (WIDTH < 1 || PRESCALE_W < 1) begin : g_illegal_params
    end

`ifdef MODE_COUNTER_PRESCALE_EN
    mode_counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .clr       (load),
        .enab      (enab),
        .presc_div (presc_div),
        .step      (step)
    );
`else
    assign step = enab;
`endif

    assign is_oneshot = (mode == MODE_ONESHOT);
    assign bound      = up_dn ? max_val : '0;
    // Only used when cnt_q is strictly inside 0..max_val, so never overflows.
    assign cnt_inc    = cnt_q + WIDTH'(1);
    assign cnt_dec    = cnt_q - WIDTH'(1);
    assign cnt_os     = up_dn ? cnt_inc : cnt_dec;

    always_comb begin
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        state_d = state_q;

        if (load) begin
            cnt_d = cnt_in;
            if (is_oneshot) begin
                state_d = ST_RUN;
                done_d  = 1'b0;
            end
        end else if (step && !(is_oneshot && state_q != ST_RUN)) begin
            if (cnt_q > max_val) begin
                cnt_d = max_val;
            end else begin
                case (mode)
                    MODE_SAT: begin
                        if (up_dn) begin
                            if (cnt_q != max_val) begin
                                cnt_d = cnt_inc;
                                tc_d  = (cnt_inc == max_val);
                            end
                        end else begin
                            if (cnt_q != '0) begin
                                cnt_d = cnt_dec;
                                tc_d  = (cnt_dec == '0);
                            end
                        end
                    end
                    MODE_ONESHOT: begin
                        if (cnt_q == bound) begin
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_os;
                            if (cnt_os == bound) begin
                                state_d = ST_DONE;
                                tc_d    = 1'b1;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        // WRAP and the reserved encoding
                        if (up_dn) begin
                            if (cnt_q == max_val) begin
                                cnt_d = '0;
                                tc_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end else begin
                            if (cnt_q == '0) begin
                                cnt_d = max_val;
                                tc_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_dec;
                            end
                        end
                    end
                endcase
            end
        end

        if (!is_oneshot) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign cnt_out = cnt_q;
    assign tc      = tc_q;
    assign done    = done_q;

endmodule : mode_counter

// File: tb/tb_mode_counter.sv
// Directed self-checking bench for mode_counter (WIDTH=8).
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       enab;
    logic       up_dn;
    logic [1:0] mode;
    logic [7:0] cnt_in;
    logic [7:0] max_val;
`ifdef MODE_COUNTER_PRESCALE_EN
    logic [3:0] presc_div;
`endif
    logic [7:0] cnt_out;
    logic       tc;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mode_counter #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .enab      (enab),
        .up_dn     (up_dn),
        .mode      (mode),
        .cnt_in    (cnt_in),
        .max_val   (max_val),
`ifdef MODE_COUNTER_PRESCALE_EN
        .presc_div (presc_div),
`endif
        .cnt_out   (cnt_out),
        .tc        (tc),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int c, input int t, input int d);
        chk({tag, ".cnt"}, int'(cnt_out), c);
        chk({tag, ".tc"}, int'(tc), t);
        chk({tag, ".done"}, int'(done), d);
        $display("step %-14s cnt=%0d tc=%0d done=%0d", tag, cnt_out, tc, done);
    endtask

    // Expected sequences for the multi-cycle runs.
    int exp_wrap_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_os_cnt  [6]  = '{1, 2, 3, 3, 3, 3};
    int exp_os_tc   [6]  = '{0, 0, 1, 0, 0, 0};
    int exp_os_done [6]  = '{0, 0, 1, 1, 1, 1};

    initial begin
        rst = 1'b1; load = 1'b0; enab = 1'b0; up_dn = 1'b1;
        mode = 2'b00; cnt_in = 8'd0; max_val = 8'd0;
`ifdef MODE_COUNTER_PRESCALE_EN
        presc_div = 4'd0;
`endif
        tick();
        tick();
        chk3("reset", 0, 0, 0);

        // WRAP up, bound 9
        rst = 1'b0; mode = 2'b00; up_dn = 1'b1; max_val = 8'd9;
        load = 1'b1; cnt_in = 8'd0;
        tick();
        chk3("wrap_up_load", 0, 0, 0);
        load = 1'b0; enab = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk3($sformatf("wrap_up%0d", k), exp_wrap_up[k], (exp_wrap_up[k] == 0) ? 1 : 0, 0);
        end

        // WRAP down, bound 5
        enab = 1'b0; up_dn = 1'b0; max_val = 8'd5; load = 1'b1; cnt_in = 8'd1;
        tick();
        chk3("wrap_dn_load", 1, 0, 0);
        load = 1'b0; enab = 1'b1;
        tick(); chk3("wrap_dn0", 0, 0, 0);
        tick(); chk3("wrap_dn1", 5, 1, 0);
        tick(); chk3("wrap_dn2", 4, 0, 0);

        // SAT up, bound 200
        enab = 1'b0; mode = 2'b01; up_dn = 1'b1; max_val = 8'd200;
        load = 1'b1; cnt_in = 8'd198;
        tick();
        load = 1'b0; enab = 1'b1;
        tick(); chk3("sat0", 199, 0, 0);
        tick(); chk3("sat1", 200, 1, 0);
        tick(); chk3("sat2", 200, 0, 0);
        tick(); chk3("sat3", 200, 0, 0);

        // Load above bound is kept; next step clamps
        enab = 1'b0; max_val = 8'd100; load = 1'b1; cnt_in = 8'd250;
        tick(); chk3("sat_ld_hi", 250, 0, 0);
        load = 1'b0; enab = 1'b1;
        tick(); chk3("sat_clamp", 100, 0, 0);

        // ONESHOT: enab in IDLE ignored
        mode = 2'b10; max_val = 8'd3;
        tick(); chk3("os_idle", 100, 0, 0);
        tick(); chk3("os_idle2", 100, 0, 0);

        enab = 1'b0; load = 1'b1; cnt_in = 8'd0;
        tick(); chk3("os_load", 0, 0, 0);
        load = 1'b0; enab = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk3($sformatf("os_up%0d", k), exp_os_cnt[k], exp_os_tc[k], exp_os_done[k]);
        end

        // Re-arm from DONE
        enab = 1'b0; load = 1'b1; cnt_in = 8'd1;
        tick(); chk3("os_rearm", 1, 0, 0);
        load = 1'b0; enab = 1'b1;
        tick(); chk3("os_run", 2, 0, 0);

        // Reset beats load and enab mid-run
        rst = 1'b1; load = 1'b1; cnt_in = 8'd7;
        tick(); chk3("os_rst", 0, 0, 0);
        rst = 1'b0; load = 1'b0;
        tick(); chk3("os_rst_idle", 0, 0, 0);

        // Loaded at the bound: first step completes without moving
        enab = 1'b0; load = 1'b1; cnt_in = 8'd3;
        tick();
        load = 1'b0; enab = 1'b1;
        tick(); chk3("os_at_bound", 3, 1, 1);

        // Leaving ONESHOT clears done
        enab = 1'b0; mode = 2'b00;
        tick(); chk3("mode_exit", 3, 0, 0);

        // ONESHOT down toward 0
        mode = 2'b10; up_dn = 1'b0; load = 1'b1; cnt_in = 8'd2;
        tick();
        load = 1'b0; enab = 1'b1;
        tick(); chk3("os_dn0", 1, 0, 0);
        tick(); chk3("os_dn1", 0, 1, 1);
        tick(); chk3("os_dn2", 0, 0, 1);

        // max_val = 0 corner cases
        enab = 1'b0; mode = 2'b00; up_dn = 1'b1; max_val = 8'd0;
        load = 1'b1; cnt_in = 8'd0;
        tick();
        load = 1'b0; enab = 1'b1;
        tick(); chk3("wrap_max0a", 0, 1, 0);
        tick(); chk3("wrap_max0b", 0, 1, 0);
        mode = 2'b01;
        tick(); chk3("sat_max0", 0, 0, 0);

        // Reserved mode behaves as WRAP
        enab = 1'b0; mode = 2'b11; max_val = 8'd2; load = 1'b1; cnt_in = 8'd2;
        tick();
        load = 1'b0; enab = 1'b1;
        tick(); chk3("rsvd_wrap", 0, 1, 0);

`ifdef MODE_COUNTER_PRESCALE_EN
        enab = 1'b0; mode = 2'b00; up_dn = 1'b1; max_val = 8'd255;
        presc_div = 4'd2; load = 1'b1; cnt_in = 8'd0;
        tick();
        load = 1'b0; enab = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk3($sformatf("presc%0d", k), k / 3, 0, 0);
        end
`endif

        enab = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mode_counter
